// File: rtl/vga_write_arbiter.sv
// Round-robin arbiter sharing the vga_adapter pixel-write port between sprite engines.
// Grants whole bursts, forwards only the owner's writes one cycle late, and reclaims the port from hung owners.
module vga_write_arbiter #(
  parameter int N        = 4,
  parameter int IDW      = 2,
  parameter int nX       = 10,
  parameter int nY       = 9,
  parameter int CW       = 9,
  parameter int MAX_HOLD = 65536
) (
  input  logic            Clock,
  input  logic            Reset,
  input  logic [N-1:0]    req,
  input  logic [N-1:0]    wr,
  input  logic [N*nX-1:0] x,
  input  logic [N*nY-1:0] y,
  input  logic [N*CW-1:0] color,
  output logic [N-1:0]    gnt,
  output logic [IDW-1:0]  owner,
  output logic            busy,
  output logic [nX-1:0]   VGA_x,
  output logic [nY-1:0]   VGA_y,
  output logic [CW-1:0]   VGA_color,
  output logic            VGA_write,
  output logic            err
);
  localparam int HW = (MAX_HOLD == 0) ? 1 : $clog2(MAX_HOLD + 1);
  localparam logic [HW-1:0] HOLD_LAST = HW'(MAX_HOLD - 1);
  localparam logic [IDW:0]  NL = (IDW + 1)'(N);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t         state_q, state_d;
  logic [IDW-1:0] ptr_q, ptr_d;
  logic [IDW-1:0] owner_q, owner_d;
  logic [N-1:0]   gnt_q, gnt_d;
  logic [HW-1:0]  hold_q, hold_d;
  logic           err_q, err_d;
  logic [nX-1:0]  vga_x_q, vga_x_d;
  logic [nY-1:0]  vga_y_q, vga_y_d;
  logic [CW-1:0]  vga_color_q, vga_color_d;
  logic           vga_write_q, vga_write_d;

  logic [IDW-1:0] win;
  logic           win_vld;
  logic [IDW:0]   sum;
  logic [IDW-1:0] owner_nxt;

  // Scan downward so the candidate closest to ptr (smallest offset) is the last to overwrite win.
  always_comb begin
    win     = '0;
    win_vld = 1'b0;
    sum     = '0;
    for (int k = N - 1; k >= 0; k--) begin
      sum = {1'b0, ptr_q} + (IDW + 1)'(k);
      if (sum >= NL) sum = sum - NL;
      if (req[sum[IDW-1:0]]) begin
        win     = sum[IDW-1:0];
        win_vld = 1'b1;
      end
    end
  end

  assign owner_nxt = (owner_q == IDW'(N - 1)) ? '0 : owner_q + IDW'(1);

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    owner_d     = owner_q;
    gnt_d       = gnt_q;
    hold_d      = hold_q;
    err_d       = err_q | (|(wr & ~gnt_q));
    vga_write_d = |(wr & gnt_q);
    vga_x_d     = vga_x_q;
    vga_y_d     = vga_y_q;
    vga_color_d = vga_color_q;
    for (int i = 0; i < N; i++) begin
      if (gnt_q[i]) begin
        vga_x_d     = x[i*nX +: nX];
        vga_y_d     = y[i*nY +: nY];
        vga_color_d = color[i*CW +: CW];
      end
    end
    if (state_q == IDLE) begin
      if (win_vld) begin
        owner_d = win;
        gnt_d   = {{(N-1){1'b0}}, 1'b1} << win;
        hold_d  = '0;
        state_d = GRANT;
      end
    end else begin
      if (hold_q != '1) hold_d = hold_q + HW'(1);
      // Returning to IDLE on every release enforces the one-cycle gap between owners.
      if (!req[owner_q] || (MAX_HOLD != 0 && hold_q == HOLD_LAST)) begin
        gnt_d   = '0;
        ptr_d   = owner_nxt;
        state_d = IDLE;
        if (req[owner_q]) err_d = 1'b1;
      end
    end
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state_q     <= IDLE;
      ptr_q       <= '0;
      owner_q     <= '0;
      gnt_q       <= '0;
      hold_q      <= '0;
      err_q       <= 1'b0;
      vga_x_q     <= '0;
      vga_y_q     <= '0;
      vga_color_q <= '0;
      vga_write_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      owner_q     <= owner_d;
      gnt_q       <= gnt_d;
      hold_q      <= hold_d;
      err_q       <= err_d;
      vga_x_q     <= vga_x_d;
      vga_y_q     <= vga_y_d;
      vga_color_q <= vga_color_d;
      vga_write_q <= vga_write_d;
    end
  end

  assign gnt       = gnt_q;
  assign owner     = owner_q;
  assign busy      = |gnt_q;
  assign VGA_x     = vga_x_q;
  assign VGA_y     = vga_y_q;
  assign VGA_color = vga_color_q;
  assign VGA_write = vga_write_q;
  assign err       = err_q;
endmodule

// File: tb/tb_vga_write_arbiter.sv
// Bench for vga_write_arbiter: directed scenarios plus random traffic against a transaction-level model.
module tb_vga_write_arbiter;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  req = '0;
  logic [3:0]  wr = '0;
  logic [39:0] x = '0;
  logic [35:0] y = '0;
  logic [35:0] color = '0;

  logic [3:0] gnt0, gnt1;
  logic [1:0] own0, own1;
  logic       busy0, busy1, vw0, vw1, err0, err1;
  logic [9:0] vx0, vx1;
  logic [8:0] vy0, vy1, vc0, vc1;
  logic [36:0] dv0, dv1;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  vga_write_arbiter dut (
    .Clock(clk), .Reset(rst), .req(req), .wr(wr), .x(x), .y(y), .color(color),
    .gnt(gnt0), .owner(own0), .busy(busy0), .VGA_x(vx0), .VGA_y(vy0),
    .VGA_color(vc0), .VGA_write(vw0), .err(err0)
  );

  vga_write_arbiter #(.MAX_HOLD(16)) dut_wd (
    .Clock(clk), .Reset(rst), .req(req), .wr(wr), .x(x), .y(y), .color(color),
    .gnt(gnt1), .owner(own1), .busy(busy1), .VGA_x(vx1), .VGA_y(vy1),
    .VGA_color(vc1), .VGA_write(vw1), .err(err1)
  );

  assign dv0 = {gnt0, own0, busy0, vx0, vy0, vc0, vw0, err0};
  assign dv1 = {gnt1, own1, busy1, vx1, vy1, vc1, vw1, err1};

  // Reference model: who holds the port, for how long, and what the adapter last saw.
  typedef struct {
    logic [3:0] gnt;
    int         owner;
    int         ptr;
    int         cnt;
    logic       err;
    logic       vw;
    logic [9:0] vx;
    logic [8:0] vy;
    logic [8:0] vc;
  } mst_t;

  mst_t m0, m1;

  function automatic mst_t mreset();
    mst_t s;
    s.gnt = '0; s.owner = 0; s.ptr = 0; s.cnt = 0; s.err = 1'b0;
    s.vw = 1'b0; s.vx = '0; s.vy = '0; s.vc = '0;
    return s;
  endfunction

  function automatic mst_t mstep(mst_t s, int max_hold);
    mst_t n = s;
    bit   found = 0;
    n.vw = |(wr & s.gnt);
    if ((wr & ~s.gnt) != 4'b0) n.err = 1'b1;
    if (s.gnt != 4'b0) begin
      n.vx = x[s.owner*10 +: 10];
      n.vy = y[s.owner*9 +: 9];
      n.vc = color[s.owner*9 +: 9];
      n.cnt = s.cnt + 1;
      if (!req[s.owner] || (max_hold != 0 && s.cnt == max_hold - 1)) begin
        if (req[s.owner]) n.err = 1'b1;
        n.gnt = '0;
        n.ptr = (s.owner + 1) % 4;
      end
    end else begin
      for (int k = 0; k < 4; k++) begin
        if (!found && req[(s.ptr + k) % 4]) begin
          found   = 1;
          n.owner = (s.ptr + k) % 4;
          n.gnt   = 4'b0001 << n.owner;
          n.cnt   = 0;
        end
      end
    end
    return n;
  endfunction

  function automatic logic [36:0] pack(mst_t s);
    return {s.gnt, 2'(s.owner), |s.gnt, s.vx, s.vy, s.vc, s.vw, s.err};
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m0 = mreset();
      m1 = mreset();
    end else begin
      m0 = mstep(m0, 65536);
      m1 = mstep(m1, 16);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst = 1'b1; req = '0; wr = '0;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; req = '0; wr = '0;
    tick(); tick();
    vectors++;
    if (dv0 !== 37'd0) begin miscompares++; $display("FAIL reset_dut: got %h want 0", dv0); end
    vectors++;
    if (dv1 !== 37'd0) begin miscompares++; $display("FAIL reset_dut_wd: got %h want 0", dv1); end
    rst = 1'b0;
  endtask

  task automatic test_single();
    logic [8:0] c;
    int pulses = 0;
    req = 4'b0001;
    tick();
    vectors++;
    if (gnt0 !== 4'b0001) begin miscompares++; $display("FAIL single_grant: got %b want 0001", gnt0); end
    for (int k = 0; k < 256; k++) begin
      c = 9'($urandom);
      wr = 4'b0001; x[9:0] = 10'(100 + k); y[8:0] = 9'd50; color[8:0] = c;
      tick();
      if (vw0) pulses++;
      vectors++;
      if ({vw0, vx0, vy0, vc0} !== {1'b1, 10'(100 + k), 9'd50, c}) begin
        miscompares++;
        $display("FAIL single_pixel k=%0d: got w=%b x=%0d y=%0d c=%h want w=1 x=%0d y=50 c=%h",
                 k, vw0, vx0, vy0, vc0, 100 + k, c);
      end
      vectors++;
      if (dv0 !== pack(m0)) begin miscompares++; $display("FAIL single_model: got %h want %h", dv0, pack(m0)); end
    end
    wr = '0; req = '0;
    tick();
    vectors++;
    if ({gnt0, vw0, err0} !== 6'b0) begin
      miscompares++; $display("FAIL single_release: got gnt=%b w=%b err=%b want 0", gnt0, vw0, err0);
    end
    vectors++;
    if (pulses !== 256) begin miscompares++; $display("FAIL single_pulses: got %0d want 256", pulses); end
  endtask

  task automatic test_round_robin();
    int idle;
    int o;
    apply_reset();
    req = 4'b1111;
    for (int g = 0; g < 5; g++) begin
      idle = 0;
      do begin tick(); idle++; end while (gnt0 == 4'b0 && idle < 20);
      vectors++;
      if (idle !== 1) begin miscompares++; $display("FAIL rr_gap g=%0d: got %0d cycles want 1", g, idle); end
      o = 0;
      for (int i = 0; i < 4; i++) if (gnt0[i]) o = i;
      vectors++;
      if (!$onehot(gnt0) || o !== g % 4) begin
        miscompares++; $display("FAIL rr_order g=%0d: got gnt=%b want owner %0d", g, gnt0, g % 4);
      end
      for (int k = 0; k < 10; k++) begin
        wr = 4'b0001 << o;
        x[o*10 +: 10] = 10'($urandom); y[o*9 +: 9] = 9'($urandom); color[o*9 +: 9] = 9'($urandom);
        tick();
        vectors++;
        if (dv0 !== pack(m0) || !$onehot(gnt0)) begin
          miscompares++; $display("FAIL rr_model: got %h want %h", dv0, pack(m0));
        end
      end
      wr = '0; req[o] = 1'b0;
      tick();
      vectors++;
      if (gnt0 !== 4'b0) begin miscompares++; $display("FAIL rr_release: got %b want 0000", gnt0); end
      req[o] = 1'b1;
    end
    req = '0;
  endtask

  task automatic test_ptr_wrap();
    req = 4'b0100; tick();
    vectors++;
    if (gnt0 !== 4'b0100) begin miscompares++; $display("FAIL wrap_grant2: got %b want 0100", gnt0); end
    req = 4'b0000; tick();
    req = 4'b0011; tick();
    vectors++;
    if (gnt0 !== 4'b0001) begin miscompares++; $display("FAIL wrap_grant0: got %b want 0001", gnt0); end
    req = 4'b0010; tick(); tick();
    vectors++;
    if (gnt0 !== 4'b0010) begin miscompares++; $display("FAIL wrap_grant1: got %b want 0010", gnt0); end
    req = '0; tick();
  endtask

  task automatic test_intruder();
    req = 4'b0010; tick();
    vectors++;
    if ({gnt0, err0} !== 5'b0010_0) begin
      miscompares++; $display("FAIL intr_grant: got gnt=%b err=%b want 0010/0", gnt0, err0);
    end
    wr = 4'b0010; color[17:9] = 9'h0A5; tick();
    vectors++;
    if ({vw0, vc0} !== {1'b1, 9'h0A5}) begin
      miscompares++; $display("FAIL intr_owner_write: got w=%b c=%h want 1/0a5", vw0, vc0);
    end
    wr = 4'b0100; color[26:18] = 9'h1FF; tick();
    vectors++;
    if ({vw0, vc0, err0} !== {1'b0, 9'h0A5, 1'b1}) begin
      miscompares++; $display("FAIL intr_drop: got w=%b c=%h err=%b want 0/0a5/1", vw0, vc0, err0);
    end
    wr = '0; tick(); tick();
    vectors++;
    if (err0 !== 1'b1) begin miscompares++; $display("FAIL intr_sticky: got %b want 1", err0); end
    req = '0; tick();
  endtask

  task automatic test_watchdog();
    int n = 0;
    apply_reset();
    req = 4'b1000; tick();
    vectors++;
    if ({gnt1, err1} !== 5'b1000_0) begin
      miscompares++; $display("FAIL wd_grant: got gnt=%b err=%b want 1000/0", gnt1, err1);
    end
    req = 4'b1001;
    while (gnt1 == 4'b1000 && n < 40) begin
      n++;
      tick();
      vectors++;
      if (dv1 !== pack(m1)) begin miscompares++; $display("FAIL wd_model: got %h want %h", dv1, pack(m1)); end
    end
    vectors++;
    if (n !== 16) begin miscompares++; $display("FAIL wd_hold: got %0d cycles want 16", n); end
    vectors++;
    if ({gnt1, err1} !== 5'b0000_1) begin
      miscompares++; $display("FAIL wd_release: got gnt=%b err=%b want 0000/1", gnt1, err1);
    end
    tick();
    vectors++;
    if (gnt1 !== 4'b0001) begin miscompares++; $display("FAIL wd_next: got %b want 0001", gnt1); end
    req = '0; tick(); tick();
  endtask

  task automatic test_mid_reset();
    apply_reset();
    req = 4'b0010; tick();
    for (int k = 0; k < 5; k++) begin
      wr = 4'b0010; x[19:10] = 10'($urandom); y[17:9] = 9'($urandom); color[17:9] = 9'($urandom);
      tick();
    end
    #2 rst = 1'b1;
    #1;
    vectors++;
    if (dv0 !== 37'd0) begin miscompares++; $display("FAIL midrst_dut: got %h want 0", dv0); end
    vectors++;
    if (dv1 !== 37'd0) begin miscompares++; $display("FAIL midrst_dut_wd: got %h want 0", dv1); end
    wr = '0; req = 4'b0100;
    #3 rst = 1'b0;
    tick();
    vectors++;
    if ({gnt0, gnt1} !== 8'b0100_0100) begin
      miscompares++; $display("FAIL midrst_regrant: got %b/%b want 0100/0100", gnt0, gnt1);
    end
    req = '0; tick();
  endtask

  task automatic test_random();
    apply_reset();
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < 4; i++) if ($urandom_range(0, 11) == 0) req[i] = ~req[i];
      if ($urandom_range(0, 19) == 0) wr = 4'($urandom);
      else wr = 4'($urandom) & gnt0;
      x = {$urandom, $urandom}; y = {$urandom, $urandom}; color = {$urandom, $urandom};
      tick();
      vectors++;
      if (dv0 !== pack(m0)) begin miscompares++; $display("FAIL rand_dut c=%0d: got %h want %h", c, dv0, pack(m0)); end
      vectors++;
      if (dv1 !== pack(m1)) begin miscompares++; $display("FAIL rand_dut_wd c=%0d: got %h want %h", c, dv1, pack(m1)); end
    end
    req = '0; wr = '0; tick();
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_ptr_wrap();
    test_intruder();
    test_watchdog();
    test_mid_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end
endmodule
